ecall_sequencer: RTL and testbench
==================================

# ecall_sequencer

Controller that sequences system-call execution for the writeback stage. When a valid ecall reaches WB, it:
- holds the pipeline;
- waits for outstanding memory writes to drain;
- optionally flushes the data cache;
- hands the latched a0–a7 to a multi-cycle service unit over a start/done handshake;
- writes the returned value to the register file and squashes younger instructions.

It sits beside the WB stage and owns the WB stall and the ecall write-port request.

## Interface
Parameters:
- FLUSH_ON_ECALL, 1, when 1 the DCACHE_FLUSH state is entered; when 0 it is skipped.
- CNT_W, 32, width of ecall_count.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- wb_valid  in  1  WB holds a non-bubble instruction.
- wb_is_ecall  in  1  WB instruction is an ecall.
- wb_rd  in  5  destination register of the WB instruction.
- args  in  8x64  a0..a7, index 0 = a0.
- mem_idle  in  1  no outstanding stores or memory responses.
- flush_req  out  1  dcache flush request, level.
- flush_ack  in  1  dcache flush complete, single-cycle pulse.
- svc_start  out  1  single-cycle pulse starting the service.
- svc_args  out  8x64  registered copy of args; stable from svc_start until svc_done.
- svc_done  in  1  service complete, single-cycle pulse.
- svc_result  in  64  valid when svc_done=1.
- stall  out  1  freeze IF..WB.
- flush_younger  out  1  squash all stages before WB.
- wr_en  out  1  register-file write enable for the ecall result.
- wr_rd  out  5  write index.
- wr_data  out  64  write data.
- busy  out  1  state != IDLE.
- ecall_count  out  CNT_W  completed ecalls.

## Operation
Trigger: `trig = wb_valid & wb_is_ecall` while in IDLE.

States and transitions:
- IDLE → DRAIN on trig.
  - args and wb_rd are latched the same edge.
- DRAIN → DCACHE_FLUSH on mem_idle, or → CALL if FLUSH_ON_ECALL=0.
  - If mem_idle is already 1 in the first DRAIN cycle, the state still spends that one cycle in DRAIN.
- DCACHE_FLUSH: flush_req=1 → CALL on flush_ack.
- CALL: svc_start=1 for exactly this cycle.
  - → COMMIT if svc_done in the same cycle, else → WAIT.
- WAIT → COMMIT on svc_done. No timeout.
- COMMIT: wr_en=1, flush_younger=1, ecall_count increments → IDLE.

Outputs and data rules:
- svc_result is captured into the wr_data register on the svc_done edge.
- stall = (state ∉ {IDLE, COMMIT}) | (state==IDLE & trig).
  - stall is the only combinational output.
  - In COMMIT, stall=0 so the ecall retires from WB on the same edge its result is written.
- wr_en is forced to 0 when the latched rd==0.
  - flush_younger and the count update still occur in COMMIT.
- Inputs are ignored in the states where they do not apply:
  - flush_ack outside DCACHE_FLUSH;
  - svc_done outside CALL/WAIT;
  - wb_* outside IDLE.
- ecall_count wraps from 2^CNT_W−1 to 0.
- A second ecall arriving back-to-back is triggered from IDLE on the cycle after COMMIT.

## Timing
- Reset (asynchronous):
  - state ← IDLE; svc_args, wr_rd, wr_data, ecall_count ← 0.
  - All registered outputs are 0.
  - stall=0 unless trig.
- Reset mid-operation abandons the call:
  - svc_start and flush_req drop immediately.
  - No write is issued.
  - A later svc_done is ignored.
- Minimum latency, trig to COMMIT, with mem_idle=1 and same-cycle ack/done: 4 cycles (DRAIN, DCACHE_FLUSH, CALL, COMMIT); 3 cycles with FLUSH_ON_ECALL=0.
- All outputs except stall are registered.
- svc_args are held from the IDLE→DRAIN edge until the next trig.

## Structure
- Package ecall_pkg:
  - `ecall_state_t` enum: IDLE, DRAIN, DCACHE_FLUSH, CALL, WAIT, COMMIT.
  - `NUM_ECALL_ARGS = 8`.
  - `ecall_args_t` as a packed [7:0][63:0] array.
- Single module, no sub-module. The FSM, capture registers and counter are small enough to keep flat.

## Test plan
- Basic call: ecall rd=10, a7=93, mem_idle=1, flush_ack and svc_done returned 1 cycle after request, svc_result=0x2A.
  - Required: svc_args[7]=93.
  - Exactly one svc_start pulse.
  - wr_en=1, wr_rd=10, wr_data=0x2A.
  - flush_younger pulses once.
  - ecall_count=1.
  - stall low in COMMIT.
- Drain wait: mem_idle=0 for 5 cycles.
  - Required: flush_req stays 0 until mem_idle rises.
  - stall held throughout.
- rd=0 with svc_result=0xFF.
  - Required: wr_en never asserts.
  - ecall_count still increments.
  - flush_younger pulses.
- Same-cycle done: svc_done=1 during CALL, FLUSH_ON_ECALL=0.
  - Required: COMMIT on the next cycle, 3 cycles after trig.
  - No WAIT state entered.
- Reset mid-operation: assert reset in WAIT, then pulse svc_done after release.
  - Required: outputs 0 immediately.
  - No wr_en.
  - ecall_count=0.
- Wrap and back-to-back: CNT_W=2, four consecutive ecalls.
  - Required: each triggers the cycle after the previous COMMIT.
  - ecall_count sequence 1, 2, 3, 0.

Source files
------------

// File: rtl/ecall_pkg.sv
// ---------------------------------------------------------------------------
// ecall_pkg
// Shared types for the writeback-stage system-call sequencer.
//   ecall_state_t  : sequencer FSM states
//   NUM_ECALL_ARGS : number of argument registers handed to the service (a0..a7)
//   ECALL_XLEN     : width of one argument / result
//   ecall_args_t   : packed a0..a7 bundle, index 0 = a0
// ---------------------------------------------------------------------------
package ecall_pkg;

   localparam int NUM_ECALL_ARGS = 8;
   localparam int ECALL_XLEN     = 64;

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      DCACHE_FLUSH,
      CALL,
      WAIT,
      COMMIT
   } ecall_state_t;

   typedef logic [NUM_ECALL_ARGS-1:0][ECALL_XLEN-1:0] ecall_args_t;

endpackage : ecall_pkg

// File: rtl/ecall_sequencer.sv
// ---------------------------------------------------------------------------
// ecall_sequencer
// Sequences a system call that has reached writeback: stalls the pipeline,
// waits for memory to go idle, optionally flushes the data cache, hands the
// latched a0..a7 to a multi-cycle service unit, then writes the returned
// value to the register file while squashing younger instructions.
//
// Parameters
//   FLUSH_ON_ECALL : 1 = visit DCACHE_FLUSH, 0 = go straight from DRAIN to CALL
//   CNT_W          : width of ecall_count (wraps)
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   wb_valid/is_ecall/rd: writeback instruction info (sampled only in IDLE)
//   args                : a0..a7 from the register file
//   mem_idle            : no outstanding stores / memory responses
//   flush_req/flush_ack : dcache flush request (level) / completion (pulse)
//   svc_start/svc_args  : service start pulse / argument copy held for service
//   svc_done/svc_result : service completion pulse / return value
//   stall               : freeze IF..WB (only combinational output)
//   flush_younger       : squash all stages before WB
//   wr_en/wr_rd/wr_data : register-file write of the ecall result
//   busy                : sequencer not in IDLE
//   ecall_count         : number of completed ecalls
// ---------------------------------------------------------------------------
module ecall_sequencer
   import ecall_pkg::*;
#(
   parameter bit FLUSH_ON_ECALL = 1'b1,
   parameter int CNT_W          = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_valid,
   input  logic              wb_is_ecall,
   input  logic [4:0]        wb_rd,
   input  ecall_args_t       args,
   input  logic              mem_idle,
   output logic              flush_req,
   input  logic              flush_ack,
   output logic              svc_start,
   output ecall_args_t       svc_args,
   input  logic              svc_done,
   input  logic [63:0]       svc_result,
   output logic              stall,
   output logic              flush_younger,
   output logic              wr_en,
   output logic [4:0]        wr_rd,
   output logic [63:0]       wr_data,
   output logic              busy,
   output logic [CNT_W-1:0]  ecall_count
);

   ecall_state_t state;
   ecall_state_t state_nxt;
   logic         trig;

   // x0 is hardwired to zero, so a result aimed at it is dropped.
   function automatic logic rd_writable(input logic [4:0] rd);
      return rd != 5'd0;
   endfunction

   assign trig = wb_valid & wb_is_ecall;

   // The ecall itself sits in WB while the sequence runs; it is released in
   // COMMIT so it retires on the same edge its result is written.
   assign stall = ((state != IDLE) && (state != COMMIT)) ||
                  ((state == IDLE) && trig);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:         if (trig) state_nxt = DRAIN;
         DRAIN:        if (mem_idle) state_nxt = FLUSH_ON_ECALL ? DCACHE_FLUSH : CALL;
         DCACHE_FLUSH: if (flush_ack) state_nxt = CALL;
         CALL:         state_nxt = svc_done ? COMMIT : WAIT;
         WAIT:         if (svc_done) state_nxt = COMMIT;
         COMMIT:       state_nxt = IDLE;
         default:      state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so each one is a flop that is
   // already correct in the first cycle of the state it belongs to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         flush_req     <= 1'b0;
         svc_start     <= 1'b0;
         svc_args      <= '0;
         flush_younger <= 1'b0;
         wr_en         <= 1'b0;
         wr_rd         <= 5'd0;
         wr_data       <= 64'd0;
         busy          <= 1'b0;
         ecall_count   <= '0;
      end else begin
         state <= state_nxt;

         // Arguments and destination are frozen for the whole call and only
         // replaced by the next ecall.
         if ((state == IDLE) && trig) begin
            svc_args <= args;
            wr_rd    <= wb_rd;
         end

         if (((state == CALL) || (state == WAIT)) && svc_done)
            wr_data <= svc_result;

         flush_req     <= (state_nxt == DCACHE_FLUSH);
         svc_start     <= (state_nxt == CALL);
         flush_younger <= (state_nxt == COMMIT);
         wr_en         <= (state_nxt == COMMIT) && rd_writable(wr_rd);
         busy          <= (state_nxt != IDLE);

         if (state_nxt == COMMIT)
            ecall_count <= ecall_count + CNT_W'(1);
      end
   end

endmodule : ecall_sequencer

// File: tb/tb_ecall_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ecall_sequencer
// Directed bench for ecall_sequencer. Two instances share all inputs:
//   dut_a : FLUSH_ON_ECALL=1, CNT_W=2 (flush path, counter wrap)
//   dut_b : FLUSH_ON_ECALL=0, CNT_W=32 (short path)
// Inputs change 1 ns after the rising edge; registered outputs are sampled
// at that point before inputs are changed.
// ---------------------------------------------------------------------------
module tb_ecall_sequencer;
   import ecall_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wb_valid = 1'b0;
   logic        wb_is_ecall = 1'b0;
   logic [4:0]  wb_rd = 5'd0;
   ecall_args_t args = '0;
   logic        mem_idle = 1'b0;
   logic        flush_ack = 1'b0;
   logic        svc_done = 1'b0;
   logic [63:0] svc_result = 64'd0;

   logic        a_flush_req, a_svc_start, a_stall, a_flush_younger, a_wr_en, a_busy;
   ecall_args_t a_svc_args;
   logic [4:0]  a_wr_rd;
   logic [63:0] a_wr_data;
   logic [1:0]  a_ecall_count;

   logic        b_flush_req, b_svc_start, b_stall, b_flush_younger, b_wr_en, b_busy;
   ecall_args_t b_svc_args;
   logic [4:0]  b_wr_rd;
   logic [63:0] b_wr_data;
   logic [31:0] b_ecall_count;

   int n_tests = 0;
   int n_fail  = 0;

   int a_start_cnt = 0;
   int a_fy_cnt    = 0;
   int a_wren_cnt  = 0;
   int b_start_cnt = 0;

   always #5 clk = ~clk;

   ecall_sequencer #(.FLUSH_ON_ECALL(1'b1), .CNT_W(2)) dut_a (
      .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_is_ecall(wb_is_ecall),
      .wb_rd(wb_rd), .args(args), .mem_idle(mem_idle), .flush_req(a_flush_req),
      .flush_ack(flush_ack), .svc_start(a_svc_start), .svc_args(a_svc_args),
      .svc_done(svc_done), .svc_result(svc_result), .stall(a_stall),
      .flush_younger(a_flush_younger), .wr_en(a_wr_en), .wr_rd(a_wr_rd),
      .wr_data(a_wr_data), .busy(a_busy), .ecall_count(a_ecall_count)
   );

   ecall_sequencer #(.FLUSH_ON_ECALL(1'b0), .CNT_W(32)) dut_b (
      .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_is_ecall(wb_is_ecall),
      .wb_rd(wb_rd), .args(args), .mem_idle(mem_idle), .flush_req(b_flush_req),
      .flush_ack(flush_ack), .svc_start(b_svc_start), .svc_args(b_svc_args),
      .svc_done(svc_done), .svc_result(svc_result), .stall(b_stall),
      .flush_younger(b_flush_younger), .wr_en(b_wr_en), .wr_rd(b_wr_rd),
      .wr_data(b_wr_data), .busy(b_busy), .ecall_count(b_ecall_count)
   );

   // Pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (a_svc_start)     a_start_cnt <= a_start_cnt + 1;
      if (a_flush_younger) a_fy_cnt    <= a_fy_cnt + 1;
      if (a_wr_en)         a_wren_cnt  <= a_wren_cnt + 1;
      if (b_svc_start)     b_start_cnt <= b_start_cnt + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #2 reset = 1'b1;
      #1;
      n_tests++;
      if ({a_busy, a_flush_req, a_svc_start, a_wr_en, a_flush_younger} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl_a: got %b expected 00000",
                  {a_busy, a_flush_req, a_svc_start, a_wr_en, a_flush_younger});
      end
      n_tests++;
      if (a_ecall_count !== 2'd0 || b_ecall_count !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_count: got a=%0d b=%0d expected 0", a_ecall_count, b_ecall_count);
      end
      n_tests++;
      if (a_svc_args !== '0 || a_wr_rd !== 5'd0 || a_wr_data !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_data: got rd=%0d data=%h expected zeros", a_wr_rd, a_wr_data);
      end
      n_tests++;
      if (a_stall !== 1'b0 || b_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_stall: got stall=%b b_busy=%b expected 0 0", a_stall, b_busy);
      end
      wb_valid = 1'b1;
      wb_is_ecall = 1'b1;
      #1;
      n_tests++;
      if (a_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_stall_trig: got %b expected 1", a_stall);
      end
      wb_valid = 1'b0;
      wb_is_ecall = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      // a non-ecall instruction must not start anything
      wb_valid = 1'b1;
      tick();
      n_tests++;
      if (a_busy !== 1'b0 || a_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL non_ecall: got busy=%b stall=%b expected 0 0", a_busy, a_stall);
      end
      wb_valid = 1'b0;
   endtask

   task automatic test_basic;
      int s0, f0;
      for (int i = 0; i < NUM_ECALL_ARGS; i++) args[i] = 64'h100 + 64'(i);
      args[7] = 64'd93;
      wb_rd = 5'd10;
      mem_idle = 1'b1;
      wb_valid = 1'b1;
      wb_is_ecall = 1'b1;
      #1;
      n_tests++;
      if (a_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_trig_stall: got %b expected 1", a_stall);
      end
      s0 = a_start_cnt;
      f0 = a_fy_cnt;
      tick(); // DRAIN
      n_tests++;
      if (a_busy !== 1'b1 || a_flush_req !== 1'b0 || a_svc_args[7] !== 64'd93 ||
          a_svc_args[0] !== 64'h100) begin
         n_fail++;
         $display("FAIL basic_drain: got busy=%b freq=%b a7=%0d a0=%h expected 1 0 93 100",
                  a_busy, a_flush_req, a_svc_args[7], a_svc_args[0]);
      end
      wb_valid = 1'b0;
      wb_is_ecall = 1'b0;
      args = '1;
      tick(); // DCACHE_FLUSH
      n_tests++;
      if (a_flush_req !== 1'b1 || a_stall !== 1'b1 || a_svc_args[7] !== 64'd93) begin
         n_fail++;
         $display("FAIL basic_flush: got freq=%b stall=%b a7=%h expected 1 1 93",
                  a_flush_req, a_stall, a_svc_args[7]);
      end
      tick();
      n_tests++;
      if (a_flush_req !== 1'b1 || a_svc_start !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_flush_hold: got freq=%b start=%b expected 1 0", a_flush_req, a_svc_start);
      end
      flush_ack = 1'b1;
      tick(); // CALL
      flush_ack = 1'b0;
      n_tests++;
      if (a_svc_start !== 1'b1 || a_flush_req !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_call: got start=%b freq=%b expected 1 0", a_svc_start, a_flush_req);
      end
      tick(); // WAIT
      n_tests++;
      if (a_svc_start !== 1'b0 || a_stall !== 1'b1 || a_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_wait: got start=%b stall=%b wr_en=%b expected 0 1 0",
                  a_svc_start, a_stall, a_wr_en);
      end
      svc_done = 1'b1;
      svc_result = 64'h2A;
      tick(); // COMMIT
      svc_done = 1'b0;
      svc_result = '1;
      n_tests++;
      if (a_wr_en !== 1'b1 || a_wr_rd !== 5'd10 || a_wr_data !== 64'h2A) begin
         n_fail++;
         $display("FAIL basic_write: got en=%b rd=%0d data=%h expected 1 10 2a",
                  a_wr_en, a_wr_rd, a_wr_data);
      end
      n_tests++;
      if (a_flush_younger !== 1'b1 || a_stall !== 1'b0 || a_ecall_count !== 2'd1) begin
         n_fail++;
         $display("FAIL basic_commit: got fy=%b stall=%b count=%0d expected 1 0 1",
                  a_flush_younger, a_stall, a_ecall_count);
      end
      tick(); // IDLE
      n_tests++;
      if (a_wr_en !== 1'b0 || a_flush_younger !== 1'b0 || a_busy !== 1'b0 ||
          a_ecall_count !== 2'd1 || a_wr_data !== 64'h2A) begin
         n_fail++;
         $display("FAIL basic_idle: got en=%b fy=%b busy=%b count=%0d data=%h expected 0 0 0 1 2a",
                  a_wr_en, a_flush_younger, a_busy, a_ecall_count, a_wr_data);
      end
      n_tests++;
      if ((a_start_cnt - s0) !== 1 || (a_fy_cnt - f0) !== 1) begin
         n_fail++;
         $display("FAIL basic_pulses: got starts=%0d fy=%0d expected 1 1",
                  a_start_cnt - s0, a_fy_cnt - f0);
      end
   endtask

   task automatic test_drain_wait;
      wb_rd = 5'd3;
      args = '0;
      mem_idle = 1'b0;
      wb_valid = 1'b1;
      wb_is_ecall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 0) begin
            wb_valid = 1'b0;
            wb_is_ecall = 1'b0;
         end
         n_tests++;
         if (a_flush_req !== 1'b0 || a_stall !== 1'b1 || a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_hold[%0d]: got freq=%b stall=%b busy=%b expected 0 1 1",
                     i, a_flush_req, a_stall, a_busy);
         end
      end
      mem_idle = 1'b1;
      tick(); // DCACHE_FLUSH
      n_tests++;
      if (a_flush_req !== 1'b1) begin
         n_fail++;
         $display("FAIL drain_release: got freq=%b expected 1", a_flush_req);
      end
      flush_ack = 1'b1;
      tick(); // CALL
      flush_ack = 1'b0;
      n_tests++;
      if (a_svc_start !== 1'b1 || a_flush_req !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_call: got start=%b freq=%b expected 1 0", a_svc_start, a_flush_req);
      end
      svc_done = 1'b1;
      svc_result = 64'h55;
      tick(); // COMMIT
      svc_done = 1'b0;
      n_tests++;
      if (a_wr_en !== 1'b1 || a_wr_data !== 64'h55 || a_wr_rd !== 5'd3 || a_ecall_count !== 2'd2) begin
         n_fail++;
         $display("FAIL drain_commit: got en=%b data=%h rd=%0d count=%0d expected 1 55 3 2",
                  a_wr_en, a_wr_data, a_wr_rd, a_ecall_count);
      end
      tick();
      n_tests++;
      if (a_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_idle: got busy=%b expected 0", a_busy);
      end
   endtask

   task automatic test_rd_zero;
      int w0, f0;
      // ack/done held high from IDLE onward: must be ignored until they apply
      flush_ack = 1'b1;
      svc_done = 1'b1;
      svc_result = 64'hFF;
      mem_idle = 1'b1;
      tick();
      n_tests++;
      if (a_busy !== 1'b0 || a_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL rd0_idle_ignore: got busy=%b en=%b expected 0 0", a_busy, a_wr_en);
      end
      w0 = a_wren_cnt;
      f0 = a_fy_cnt;
      wb_rd = 5'd0;
      wb_valid = 1'b1;
      wb_is_ecall = 1'b1;
      tick(); // DRAIN
      wb_valid = 1'b0;
      wb_is_ecall = 1'b0;
      tick(); // DCACHE_FLUSH
      tick(); // CALL
      tick(); // COMMIT
      n_tests++;
      if (a_flush_younger !== 1'b1 || a_wr_en !== 1'b0 || a_ecall_count !== 2'd3 ||
          a_wr_data !== 64'hFF) begin
         n_fail++;
         $display("FAIL rd0_commit: got fy=%b en=%b count=%0d data=%h expected 1 0 3 ff",
                  a_flush_younger, a_wr_en, a_ecall_count, a_wr_data);
      end
      tick();
      flush_ack = 1'b0;
      svc_done = 1'b0;
      n_tests++;
      if (a_busy !== 1'b0 || (a_wren_cnt - w0) !== 0 || (a_fy_cnt - f0) !== 1) begin
         n_fail++;
         $display("FAIL rd0_pulses: got busy=%b wr_en_pulses=%0d fy_pulses=%0d expected 0 0 1",
                  a_busy, a_wren_cnt - w0, a_fy_cnt - f0);
      end
   endtask

   task automatic test_same_cycle_done;
      int s0;
      flush_ack = 1'b1;
      svc_done = 1'b1;
      svc_result = 64'h1234;
      mem_idle = 1'b1;
      wb_rd = 5'd7;
      wb_valid = 1'b1;
      wb_is_ecall = 1'b1;
      s0 = b_start_cnt;
      tick(); // DRAIN (both)
      wb_valid = 1'b0;
      wb_is_ecall = 1'b0;
      n_tests++;
      if (b_busy !== 1'b1 || b_svc_start !== 1'b0) begin
         n_fail++;
         $display("FAIL same_drain: got busy=%b start=%b expected 1 0", b_busy, b_svc_start);
      end
      tick(); // b: CALL, a: DCACHE_FLUSH
      n_tests++;
      if (b_svc_start !== 1'b1 || b_stall !== 1'b1 || b_flush_req !== 1'b0) begin
         n_fail++;
         $display("FAIL same_call: got start=%b stall=%b freq=%b expected 1 1 0",
                  b_svc_start, b_stall, b_flush_req);
      end
      tick(); // b: COMMIT, a: CALL
      n_tests++;
      if (b_wr_en !== 1'b1 || b_wr_data !== 64'h1234 || b_wr_rd !== 5'd7 ||
          b_flush_younger !== 1'b1 || b_stall !== 1'b0 || b_ecall_count !== 32'd4) begin
         n_fail++;
         $display("FAIL same_commit: got en=%b data=%h rd=%0d fy=%b stall=%b count=%0d expected 1 1234 7 1 0 4",
                  b_wr_en, b_wr_data, b_wr_rd, b_flush_younger, b_stall, b_ecall_count);
      end
      n_tests++;
      if (a_svc_start !== 1'b1 || a_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL min_lat_a_call: got start=%b en=%b expected 1 0", a_svc_start, a_wr_en);
      end
      tick(); // b: IDLE, a: COMMIT
      n_tests++;
      if (b_busy !== 1'b0 || (b_start_cnt - s0) !== 1) begin
         n_fail++;
         $display("FAIL same_idle: got busy=%b starts=%0d expected 0 1", b_busy, b_start_cnt - s0);
      end
      n_tests++;
      if (a_wr_en !== 1'b1 || a_wr_data !== 64'h1234 || a_ecall_count !== 2'd0) begin
         n_fail++;
         $display("FAIL min_lat_a_commit: got en=%b data=%h count=%0d expected 1 1234 0",
                  a_wr_en, a_wr_data, a_ecall_count);
      end
      flush_ack = 1'b0;
      svc_done = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid;
      int w0;
      for (int i = 0; i < NUM_ECALL_ARGS; i++) args[i] = 64'hA0 + 64'(i);
      wb_rd = 5'd9;
      mem_idle = 1'b1;
      flush_ack = 1'b1;
      wb_valid = 1'b1;
      wb_is_ecall = 1'b1;
      tick(); // DRAIN
      wb_valid = 1'b0;
      wb_is_ecall = 1'b0;
      tick(); // DCACHE_FLUSH
      tick(); // CALL
      tick(); // WAIT
      flush_ack = 1'b0;
      n_tests++;
      if (a_busy !== 1'b1 || a_svc_start !== 1'b0 || b_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_in_wait: got a_busy=%b start=%b b_busy=%b expected 1 0 1",
                  a_busy, a_svc_start, b_busy);
      end
      w0 = a_wren_cnt;
      reset = 1'b1;
      #1;
      n_tests++;
      if ({a_busy, a_flush_req, a_svc_start, a_wr_en, a_flush_younger, a_stall} !== 6'b0) begin
         n_fail++;
         $display("FAIL mid_reset_ctrl: got %b expected 000000",
                  {a_busy, a_flush_req, a_svc_start, a_wr_en, a_flush_younger, a_stall});
      end
      n_tests++;
      if (a_svc_args !== '0 || a_wr_rd !== 5'd0 || b_ecall_count !== 32'd0 || b_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_data: got rd=%0d b_count=%0d b_busy=%b expected 0 0 0",
                  a_wr_rd, b_ecall_count, b_busy);
      end
      tick();
      reset = 1'b0;
      svc_done = 1'b1;
      svc_result = 64'hDEAD;
      tick();
      svc_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (a_wr_en !== 1'b0 || a_busy !== 1'b0 || a_ecall_count !== 2'd0 ||
             b_wr_en !== 1'b0 || b_ecall_count !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_after[%0d]: got a_en=%b a_busy=%b a_count=%0d b_en=%b b_count=%0d expected 0 0 0 0 0",
                     i, a_wr_en, a_busy, a_ecall_count, b_wr_en, b_ecall_count);
         end
      end
      n_tests++;
      if ((a_wren_cnt - w0) !== 0) begin
         n_fail++;
         $display("FAIL mid_no_write: got wr_en_pulses=%0d expected 0", a_wren_cnt - w0);
      end
   endtask

   task automatic test_back_to_back;
      logic [1:0] exp_cnt;
      flush_ack = 1'b1;
      svc_done = 1'b1;
      mem_idle = 1'b1;
      wb_valid = 1'b1;
      wb_is_ecall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_cnt = 2'(k + 1);
         wb_rd = 5'(k + 1);
         svc_result = 64'h500 + 64'(k);
         #1;
         n_tests++;
         if (a_busy !== 1'b0 || a_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_idle[%0d]: got busy=%b stall=%b expected 0 1", k, a_busy, a_stall);
         end
         tick(); // DRAIN
         n_tests++;
         if (a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_trig[%0d]: got busy=%b expected 1", k, a_busy);
         end
         tick(); // DCACHE_FLUSH
         tick(); // CALL
         tick(); // COMMIT
         n_tests++;
         if (a_wr_en !== 1'b1 || a_wr_rd !== 5'(k + 1) || a_flush_younger !== 1'b1 ||
             a_stall !== 1'b0 || a_ecall_count !== exp_cnt || a_wr_data !== 64'h500 + 64'(k)) begin
            n_fail++;
            $display("FAIL b2b_commit[%0d]: got en=%b rd=%0d fy=%b stall=%b count=%0d data=%h expected 1 %0d 1 0 %0d %h",
                     k, a_wr_en, a_wr_rd, a_flush_younger, a_stall, a_ecall_count, a_wr_data,
                     k + 1, exp_cnt, 64'h500 + 64'(k));
         end
         if (k == 3) begin
            wb_valid = 1'b0;
            wb_is_ecall = 1'b0;
         end
         tick(); // IDLE
      end
      flush_ack = 1'b0;
      svc_done = 1'b0;
      tick();
      n_tests++;
      if (a_busy !== 1'b0 || a_ecall_count !== 2'd0) begin
         n_fail++;
         $display("FAIL b2b_end: got busy=%b count=%0d expected 0 0", a_busy, a_ecall_count);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_drain_wait();
      test_rd_zero();
      test_same_cycle_done();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_ecall_sequencer
